// File: rtl/display_msg_scroller.sv
// Seven-segment message scroller: shows one of four fixed messages on N_DIGITS
// digits, either static, scrolling through a MSG_LEN character ring, or blinking.
module display_msg_scroller #(
    parameter int N_DIGITS = 6,
    parameter int MSG_LEN  = 8,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            msgSel,
    input  logic [3:0]            nivel,
    input  logic [1:0]            mode,
    output logic [7*N_DIGITS-1:0] hex,
    output logic                  wrapPulse
);
    localparam int OW = $clog2(MSG_LEN);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [OW-1:0] OFF_LAST   = OW'(MSG_LEN - 1);

    function automatic logic [6:0] digit_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = 7'b0111111;
        endcase
        return g;
    endfunction

    // Ring slots 6 and above are always blank, as is the whole of message 11.
    function automatic logic [6:0] msg_char(input logic [1:0] sel, input logic [3:0] lvl,
                                            input int idx);
        logic [6:0] g;
        g = 7'b1111111;
        case (sel)
            2'b00: case (idx)
                0: g = 7'b1001000;
                1: g = 7'b1111001;
                2: g = 7'b1000001;
                3: g = 7'b0000110;
                4: g = 7'b1000111;
                5: g = digit_glyph(lvl);
                default: ;
            endcase
            2'b01: case (idx)
                0: g = 7'b1000001;
                1: g = 7'b0000110;
                2: g = 7'b1001000;
                3: g = 7'b1000110;
                4: g = 7'b0000110;
                5: g = 7'b1000001;
                default: ;
            endcase
            2'b10: case (idx)
                0: g = 7'b0001100;
                1: g = 7'b0000110;
                2: g = 7'b0101111;
                3: g = 7'b0100001;
                4: g = 7'b0000110;
                5: g = 7'b1000001;
                default: ;
            endcase
            default: ;
        endcase
        return g;
    endfunction

    // Offset and digit position are each below MSG_LEN, so one subtraction wraps.
    function automatic int ring_idx(input logic [OW-1:0] off, input int k);
        int s;
        s = int'(off) + N_DIGITS - 1 - k;
        return (s >= MSG_LEN) ? s - MSG_LEN : s;
    endfunction

    logic [PW-1:0]         presc, presc_nxt;
    logic [OW-1:0]         offset, offset_nxt;
    logic                  blink_vis, blink_nxt;
    logic [1:0]            sel_q, mode_q;
    logic [3:0]            nivel_q;
    logic                  restart, tick, is_scroll, is_blink, wrap_nxt;
    logic [7*N_DIGITS-1:0] hex_nxt;

    always_comb begin
        restart    = (msgSel != sel_q) || (nivel != nivel_q) || (mode != mode_q);
        is_scroll  = (mode == 2'b01);
        is_blink   = (mode == 2'b10);
        tick       = enable && (presc == PRESC_LAST);
        presc_nxt  = presc;
        offset_nxt = offset;
        blink_nxt  = blink_vis;
        wrap_nxt   = 1'b0;
        if (restart) begin
            presc_nxt  = '0;
            offset_nxt = '0;
            blink_nxt  = 1'b1;
        end else if (enable) begin
            presc_nxt = tick ? '0 : presc + 1'b1;
            if (!is_scroll) begin
                offset_nxt = '0;
            end else if (tick) begin
                offset_nxt = (offset == OFF_LAST) ? '0 : offset + 1'b1;
                wrap_nxt   = (offset == OFF_LAST);
            end
            if (!is_blink) begin
                blink_nxt = 1'b1;
            end else if (tick) begin
                blink_nxt = !blink_vis;
            end
        end
    end

    // The display register is loaded from the state being committed on the same edge.
    always_comb begin
        hex_nxt = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            hex_nxt[7*k +: 7] = blink_nxt ? msg_char(msgSel, nivel, ring_idx(offset_nxt, k))
                                          : 7'b1111111;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            offset    <= '0;
            blink_vis <= 1'b1;
            sel_q     <= '0;
            nivel_q   <= '0;
            mode_q    <= '0;
            hex       <= '1;
            wrapPulse <= 1'b0;
        end else begin
            presc     <= presc_nxt;
            offset    <= offset_nxt;
            blink_vis <= blink_nxt;
            sel_q     <= msgSel;
            nivel_q   <= nivel;
            mode_q    <= mode;
            hex       <= hex_nxt;
            wrapPulse <= wrap_nxt;
        end
    end
endmodule

// File: tb/tb_display_msg_scroller.sv
// Randomized scoreboard bench for display_msg_scroller using a character-level reference model.
module tb_display_msg_scroller;
    localparam int ND = 6;
    localparam int ML = 8;
    localparam int TD = 4;
    localparam int W  = 7*ND + 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic [1:0]      msgSel;
    logic [3:0]      nivel;
    logic [1:0]      mode;
    logic [7*ND-1:0] hex;
    logic            wrapPulse;

    display_msg_scroller #(.N_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
        .clock(clock), .reset(reset), .enable(enable), .msgSel(msgSel),
        .nivel(nivel), .mode(mode), .hex(hex), .wrapPulse(wrapPulse)
    );

    always #5 clock = ~clock;

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_cycle = 0;

    // Reference state: enabled cycles since last tick, scroll position, blink visibility.
    int         m_cnt, m_off;
    bit         m_vis;
    logic [1:0] l_sel, l_mode;
    logic [3:0] l_lvl;

    function automatic logic [6:0] glyph(input byte c);
        case (c)
            "n": return 7'b1001000;
            "i": return 7'b1111001;
            "v": return 7'b1000001;
            "e": return 7'b0000110;
            "l": return 7'b1000111;
            "u": return 7'b1000001;
            "c": return 7'b1000110;
            "d": return 7'b0100001;
            "r": return 7'b0101111;
            "p": return 7'b0001100;
            "-": return 7'b0111111;
            "0": return 7'b1000000;
            "1": return 7'b1111001;
            "2": return 7'b0100100;
            "3": return 7'b0110000;
            "4": return 7'b0011001;
            "5": return 7'b0010010;
            "6": return 7'b0000010;
            "7": return 7'b1111000;
            "8": return 7'b0000000;
            "9": return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic byte ring_char(input logic [1:0] sel, input logic [3:0] lvl, input int i);
        string s;
        if (i >= 6) return " ";
        case (sel)
            2'd0: begin
                if (i == 5) return (lvl <= 9) ? byte'(8'd48 + 8'(lvl)) : "-";
                s = "nivel";
            end
            2'd1: s = "venceu";
            2'd2: s = "perdeu";
            default: return " ";
        endcase
        return s.getc(i);
    endfunction

    function automatic logic [7*ND-1:0] render(input logic [1:0] sel, input logic [3:0] lvl,
                                               input int off, input bit vis);
        logic [7*ND-1:0] r;
        for (int k = 0; k < ND; k++) begin
            r[7*k +: 7] = vis ? glyph(ring_char(sel, lvl, (off + ND - 1 - k) % ML)) : 7'b1111111;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_off = 0; m_vis = 1;
        l_sel = 0; l_lvl = 0; l_mode = 0;
    endtask

    task automatic model_edge(input logic en, input logic [1:0] sel, input logic [3:0] lvl,
                              input logic [1:0] md, output logic wrap);
        bit tk;
        wrap = 1'b0;
        if (sel != l_sel || lvl != l_lvl || md != l_mode) begin
            m_cnt = 0; m_off = 0; m_vis = 1;
        end else if (en) begin
            tk = (m_cnt == TD - 1);
            m_cnt = (m_cnt + 1) % TD;
            if (md == 2'b01 && tk) begin
                wrap  = (m_off == ML - 1);
                m_off = (m_off + 1) % ML;
            end
            if (md == 2'b10 && tk) m_vis = !m_vis;
        end
        l_sel = sel; l_lvl = lvl; l_mode = md;
    endtask

    // One clock of stimulus; rst=1 asserts reset between edges and checks the async blanking.
    task automatic step(input logic rst, input logic en, input logic [1:0] sel,
                        input logic [3:0] lvl, input logic [1:0] md);
        logic wrap;
        @(negedge clock);
        enable = en; msgSel = sel; nivel = lvl; mode = md;
        if (rst) begin
            #2 reset = 1'b1;
            #1;
            n_tests++;
            if (hex !== '1 || wrapPulse !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL async_reset t=%0t: got wrap=%b hex=%h, expected wrap=0 hex=all ones",
                         $time, wrapPulse, hex);
            end
            model_reset();
            exp_q.push_back({1'b0, {(W-1){1'b1}}});
        end else begin
            reset = 1'b0;
            model_edge(en, sel, lvl, md, wrap);
            exp_q.push_back({wrap, render(sel, lvl, m_off, m_vis)});
        end
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(posedge clock);
            #1;
            n_cycle++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({wrapPulse, hex} !== e) begin
                    n_fail++;
                    $display("[TB] FAIL out cycle %0d: got wrap=%b hex=%h, expected wrap=%b hex=%h",
                             n_cycle, wrapPulse, hex, e[W-1], e[W-2:0]);
                end
            end
        end
    end

    initial begin : driver
        logic [1:0] sel, md;
        logic [3:0] lvl;
        int len, guard;
        reset = 1'b0; enable = 1'b0; msgSel = '0; nivel = '0; mode = '0;
        model_reset();
        #1 reset = 1'b1;
        step(1, 1, 2'd0, 4'd1, 2'd0);
        step(1, 1, 2'd0, 4'd1, 2'd0);

        // Static "nivel1"
        for (int i = 0; i < 12; i++) step(0, 1, 2'd0, 4'd1, 2'd0);
        // Scroll "venceu" through a full ring and beyond
        for (int i = 0; i < 40; i++) step(0, 1, 2'd1, 4'd1, 2'd1);
        // Blink "perdeu", freeze mid-phase, resume
        for (int i = 0; i < 14; i++) step(0, 1, 2'd2, 4'd1, 2'd2);
        for (int i = 0; i < 6; i++)  step(0, 0, 2'd2, 4'd1, 2'd2);
        for (int i = 0; i < 10; i++) step(0, 1, 2'd2, 4'd1, 2'd2);

        // Scroll to offset 5 with a tick due, then change nivel on that edge
        step(0, 1, 2'd0, 4'd1, 2'd1);
        guard = 0;
        while (!(m_off == 5 && m_cnt == TD - 1) && guard < 200) begin
            step(0, 1, 2'd0, 4'd1, 2'd1);
            guard++;
        end
        n_tests++;
        if (guard >= 200) begin
            n_fail++;
            $display("[TB] FAIL reach_offset5: got offset=%0d cnt=%0d, expected offset=5 cnt=%0d",
                     m_off, m_cnt, TD - 1);
        end
        step(0, 1, 2'd0, 4'd12, 2'd1);
        for (int i = 0; i < 10; i++) step(0, 1, 2'd0, 4'd12, 2'd1);

        // Reset in the middle of a scroll, then resume
        for (int i = 0; i < 15; i++) step(0, 1, 2'd1, 4'd3, 2'd1);
        step(1, 1, 2'd1, 4'd3, 2'd1);
        for (int i = 0; i < 40; i++) step(0, 1, 2'd1, 4'd3, 2'd1);

        // Randomized segments
        for (int s = 0; s < 70; s++) begin
            sel = 2'($urandom_range(0, 3));
            lvl = 4'($urandom_range(0, 15));
            md  = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 45);
            if ($urandom_range(0, 15) == 0) step(1, 1, sel, lvl, md);
            for (int c = 0; c < len; c++) step(0, ($urandom_range(0, 99) < 85), sel, lvl, md);
        end

        @(posedge clock);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
